// File: rtl/rot_mult_decoder_pkg.sv
// Shared widths, state encoding and rotation helpers for the rotate-multiply codec.
// The encode datapath imports the same package so both sides agree on widths.
package rot_mult_decoder_pkg;

    localparam int NUM_W  = 4;
    localparam int KEY_W  = 4;
    localparam int PROD_W = NUM_W + KEY_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic ROT_L1 = 1'b0;
    localparam logic ROT_L2 = 1'b1;

    // Undo the encoder's left rotation by rotating right by the same amount.
    function automatic logic [NUM_W-1:0] rot_right(input logic [NUM_W-1:0] v, input logic sel);
        logic [NUM_W-1:0] r;
        if (sel == ROT_L2) begin
            r = {v[1:0], v[NUM_W-1:2]};
        end else begin
            r = {v[0], v[NUM_W-1:1]};
        end
        return r;
    endfunction

endpackage

// File: rtl/rot_mult_decoder_seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock, MSB first.
// done_o is high during the cycle whose closing edge performs the final step.
module seq_divider
    import rot_mult_decoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [PROD_W-1:0] dividend_i,
    input  logic [KEY_W-1:0]  divisor_i,
    output logic              done_o,
    output logic [KEY_W:0]    rem_o,
    output logic [PROD_W-1:0] quo_o
);

    localparam int CNT_W = $clog2(PROD_W);

    logic [PROD_W-1:0] dvd_q, dvd_d;
    logic [KEY_W-1:0]  dvs_q, dvs_d;
    logic [KEY_W:0]    rem_q, rem_d;
    logic [PROD_W-1:0] quo_q, quo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              active_q, active_d;

    logic [KEY_W:0]    trial_s;
    logic [KEY_W:0]    diff_s;
    logic              ge_s;

    // The remainder MSB stands for the bit shifted out of trial_s, so it forces ge.
    always_comb begin
        trial_s = {rem_q[KEY_W-1:0], dvd_q[cnt_q]};
        diff_s  = trial_s - {1'b0, dvs_q};
        ge_s    = rem_q[KEY_W] || (trial_s >= {1'b0, dvs_q});
    end

    // Next-state for operands, partial remainder, quotient and step counter.
    always_comb begin
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start_i) begin
            dvd_d    = dividend_i;
            dvs_d    = divisor_i;
            rem_d    = {(KEY_W+1){1'b0}};
            quo_d    = {PROD_W{1'b0}};
            cnt_d    = CNT_W'(PROD_W - 1);
            active_d = (divisor_i != {KEY_W{1'b0}});
        end else if (active_q) begin
            rem_d        = ge_s ? diff_s : trial_s;
            quo_d[cnt_q] = ge_s;
            if (cnt_q == {CNT_W{1'b0}}) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else begin
            active_d = 1'b0;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_q    <= {PROD_W{1'b0}};
            dvs_q    <= {KEY_W{1'b0}};
            rem_q    <= {(KEY_W+1){1'b0}};
            quo_q    <= {PROD_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            active_q <= 1'b0;
        end else begin
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign done_o = active_q && (cnt_q == {CNT_W{1'b0}});
    assign rem_o  = rem_q;
    assign quo_o  = quo_q;

endmodule

// File: rtl/rot_mult_decoder.sv
// Recovers the original number from a stored product: divide by key, check, rotate back.
// Control FSM, error merge and inverse rotation; the arithmetic lives in seq_divider.
module rot_mult_decoder
    import rot_mult_decoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PROD_W-1:0] product,
    input  logic [KEY_W-1:0]  key,
    input  logic              rot_sel,
    output logic              busy,
    output logic              done,
    output logic [NUM_W-1:0]  num_out,
    output logic              err
);

    state_t            state_q, state_d;
    logic              rot_q, rot_d;
    logic              dz_q, dz_d;
    logic              done_q, done_d;
    logic [NUM_W-1:0]  num_q, num_d;
    logic              err_q, err_d;

    logic              accept_s;
    logic              div_done_s;
    logic [KEY_W:0]    rem_s;
    logic [PROD_W-1:0] quo_s;
    logic              fin_err_s;

    // The done cycle is still an exit cycle, so a start seen there is dropped.
    assign accept_s = (state_q == IDLE) && start && !done_q;

    seq_divider u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (accept_s),
        .dividend_i (product),
        .divisor_i  (key),
        .done_o     (div_done_s),
        .rem_o      (rem_s),
        .quo_o      (quo_s)
    );

    assign fin_err_s = dz_q || (rem_s != {(KEY_W+1){1'b0}})
                     || (quo_s[PROD_W-1:NUM_W] != {(PROD_W-NUM_W){1'b0}});

    // FSM next-state and registered result computation.
    always_comb begin
        state_d = state_q;
        rot_d   = rot_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        num_d   = num_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    rot_d   = rot_sel;
                    dz_d    = (key == {KEY_W{1'b0}});
                    state_d = (key == {KEY_W{1'b0}}) ? FIN : DIV;
                end else begin
                    state_d = IDLE;
                end
            end
            DIV: begin
                if (div_done_s) begin
                    state_d = FIN;
                end else begin
                    state_d = DIV;
                end
            end
            FIN: begin
                err_d   = fin_err_s;
                num_d   = fin_err_s ? {NUM_W{1'b0}} : rot_right(quo_s[NUM_W-1:0], rot_q);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rot_q   <= ROT_L1;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
            num_q   <= {NUM_W{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rot_q   <= rot_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
            num_q   <= num_d;
            err_q   <= err_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign num_out = num_q;
    assign err     = err_q;

endmodule

// File: tb/tb_rot_mult_decoder.sv
// Scoreboard bench: stimulus pushes arithmetic-model expectations, a monitor checks each done.
module tb_rot_mult_decoder;
    import rot_mult_decoder_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [PROD_W-1:0] product = 8'd0;
    logic [KEY_W-1:0]  key = 4'd0;
    logic              rot_sel = 1'b0;
    logic              busy, done, err;
    logic [NUM_W-1:0]  num_out;

    typedef struct {
        int num;
        int err;
        int lat;
        int t0;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    rot_mult_decoder dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .product (product),
        .key     (key),
        .rot_sel (rot_sel),
        .busy    (busy),
        .done    (done),
        .num_out (num_out),
        .err     (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: integer division, then rotate the 4-bit quotient right by 1 or 2.
    function automatic exp_t model(input int p, input int k, input int r, input int t0);
        exp_t e;
        int q, rm;
        e.t0 = t0;
        if (k == 0) begin
            e.num = 0; e.err = 1; e.lat = 1;
        end else begin
            q = p / k;
            rm = p % k;
            e.lat = 9;
            if (rm != 0 || q > 15) begin
                e.num = 0; e.err = 1;
            end else begin
                e.err = 0;
                if (r != 0) e.num = (q / 4) + (q % 4) * 4;
                else        e.num = (q / 2) + (q % 2) * 8;
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                check("num_out", int'(num_out), e.num);
                check("err", int'(err), e.err);
                check("latency", cyc - e.t0, e.lat);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("idle_timeout", 1, 0);
    endtask

    task automatic decode(input int p, input int k, input int r);
        wait_idle();
        product = p[PROD_W-1:0];
        key     = k[KEY_W-1:0];
        rot_sel = r[0];
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back(model(p, k, r, cyc));
        check("busy_after_accept", int'(busy), 1);
        product = $urandom_range(0, 255);
        key     = $urandom_range(0, 15);
        rot_sel = $urandom_range(0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("drain_timeout", 1, 0);
    endtask

    initial begin
        int p, k, r, q, n;
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_num", int'(num_out), 0);
        check("rst_err", int'(err), 0);
        @(negedge clk);
        rst = 1'b0;

        decode(8, 8, 0);
        decode(30, 10, 1);
        decode(98, 14, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b1; product = 8'd5; key = 4'd1;
        @(negedge clk);
        start = 1'b0;
        drain();

        decode(9, 2, 0);
        decode(255, 15, 1);
        decode(77, 0, 0);
        decode(60, 5, 1);

        // Start presented in the done cycle must be dropped.
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("done_wait_timeout", 1, 0);
        start = 1'b1; product = 8'd12; key = 4'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        drain();

        // Asynchronous reset mid-decode abandons the operation.
        decode(8, 8, 0);
        drain();
        decode(30, 10, 1);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_num", int'(num_out), 0);
        check("midrst_err", int'(err), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        decode(30, 10, 1);
        drain();

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 15);
            r = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 1) begin
                q = $urandom_range(0, 16);
                p = (q * k) % 256;
            end else begin
                p = $urandom_range(0, 255);
            end
            decode(p, k, r);
        end
        drain();
        check("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
